// File: rtl/display_scan_decoder.sv
// rtl/display_scan_decoder.sv - readback of a multiplexed 7-segment scan into BCD frames
module display_scan_decoder #(
    parameter int N_DIGITS = 8,
    parameter int SETTLE   = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_DIGITS-1:0]   an_i,
    input  logic [7:0]            dec_cat_i,
    input  logic                  clr_err_i,
    output logic [4*N_DIGITS-1:0] digits_o,
    output logic [N_DIGITS-1:0]   dp_mask_o,
    output logic [N_DIGITS-1:0]   bad_mask_o,
    output logic                  frame_valid_o,
    output logic                  frame_chg_o,
    output logic                  dark_o,
    output logic                  ghost_err_o
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int ZW = $clog2(N_DIGITS + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE_S, HOLD} state_t;

    state_t                state_q, state_d;
    logic [N_DIGITS-1:0]   an_q, lat_an_q, lat_an_d;
    logic [7:0]            cat_q, lat_cat_q, lat_cat_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic [4*N_DIGITS-1:0] stg_dig_q, stg_dig_d, digits_q, digits_d;
    logic [N_DIGITS-1:0]   stg_dp_q, stg_dp_d, stg_bad_q, stg_bad_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d, bad_q, bad_d;
    logic                  fv_q, fv_d, chg_q, chg_d, ghost_q, ghost_d;

    logic [ZW-1:0]         nlow;
    logic [IW-1:0]         idx;
    logic                  onehot, multi, all_off, same, capture, commit, enter_dark;
    logic [4:0]            dec;

    // {bad, nibble} for an active-high g..a pattern
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h3F:   return 5'h00;
            7'h06:   return 5'h01;
            7'h5B:   return 5'h02;
            7'h4F:   return 5'h03;
            7'h66:   return 5'h04;
            7'h6D:   return 5'h05;
            7'h7D:   return 5'h06;
            7'h07:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h6F:   return 5'h09;
            7'h40:   return 5'h0A;
            7'h00:   return 5'h0F;
            default: return 5'h1E;
        endcase
    endfunction

    always_comb begin
        nlow = '0;
        idx  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_q[i]) begin
                nlow = nlow + ZW'(1);
                idx  = IW'(i);
            end
        end
    end

    assign onehot  = (nlow == ZW'(1));
    assign multi   = (nlow > ZW'(1));
    assign all_off = (nlow == '0);
    assign same    = onehot && (an_q == lat_an_q) && (cat_q == lat_cat_q);
    assign dec     = decode_seg(~cat_q[6:0]);
    assign commit  = &seen_q;

    // A change seen in HOLD or SETTLE_S is handled exactly like a fresh start from IDLE
    always_comb begin
        state_d   = state_q;
        lat_an_d  = lat_an_q;
        lat_cat_d = lat_cat_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        if (state_q != IDLE && same) begin
            if (state_q == SETTLE_S) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(SETTLE)) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
        end else if (onehot) begin
            lat_an_d  = an_q;
            lat_cat_d = cat_q;
            cnt_d     = CW'(1);
            if (CW'(SETTLE) == CW'(1)) begin
                capture = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = SETTLE_S;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_comb begin
        tcnt_d = tcnt_q;
        if (!all_off)
            tcnt_d = '0;
        else if (tcnt_q != TW'(TIMEOUT))
            tcnt_d = tcnt_q + TW'(1);
        enter_dark = (tcnt_d == TW'(TIMEOUT)) && (tcnt_q != TW'(TIMEOUT));

        stg_dig_d = stg_dig_q;
        stg_dp_d  = stg_dp_q;
        stg_bad_d = stg_bad_q;
        seen_d    = commit ? '0 : seen_q;
        if (capture) begin
            stg_dig_d[4*idx +: 4] = dec[3:0];
            stg_bad_d[idx]        = dec[4];
            stg_dp_d[idx]         = ~cat_q[7];
            seen_d[idx]           = 1'b1;
        end
        if (enter_dark)
            seen_d = '0;

        digits_d = digits_q;
        dp_d     = dp_q;
        bad_d    = bad_q;
        fv_d     = commit;
        chg_d    = commit && ({stg_dig_q, stg_dp_q} != {digits_q, dp_q});
        if (commit) begin
            digits_d = stg_dig_q;
            dp_d     = stg_dp_q;
            bad_d    = stg_bad_q;
        end

        ghost_d = multi ? 1'b1 : (clr_err_i ? 1'b0 : ghost_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_q      <= '1;
            cat_q     <= '1;
            state_q   <= IDLE;
            lat_an_q  <= '1;
            lat_cat_q <= '1;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            seen_q    <= '0;
            stg_dig_q <= {N_DIGITS{4'hF}};
            stg_dp_q  <= '0;
            stg_bad_q <= '0;
            digits_q  <= {N_DIGITS{4'hF}};
            dp_q      <= '0;
            bad_q     <= '0;
            fv_q      <= 1'b0;
            chg_q     <= 1'b0;
            ghost_q   <= 1'b0;
        end else begin
            an_q      <= an_i;
            cat_q     <= dec_cat_i;
            state_q   <= state_d;
            lat_an_q  <= lat_an_d;
            lat_cat_q <= lat_cat_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            seen_q    <= seen_d;
            stg_dig_q <= stg_dig_d;
            stg_dp_q  <= stg_dp_d;
            stg_bad_q <= stg_bad_d;
            digits_q  <= digits_d;
            dp_q      <= dp_d;
            bad_q     <= bad_d;
            fv_q      <= fv_d;
            chg_q     <= chg_d;
            ghost_q   <= ghost_d;
        end
    end

    assign digits_o      = digits_q;
    assign dp_mask_o     = dp_q;
    assign bad_mask_o    = bad_q;
    assign frame_valid_o = fv_q;
    assign frame_chg_o   = chg_q;
    assign dark_o        = all_off && (tcnt_q == TW'(TIMEOUT));
    assign ghost_err_o   = ghost_q;
endmodule

// File: tb/tb_display_scan_decoder.sv
// tb/tb_display_scan_decoder.sv - scoreboard bench for display_scan_decoder
module tb_display_scan_decoder;
    localparam int ND      = 8;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic        clk, rst_n, clr_err;
    logic [7:0]  an, dec_cat;
    logic [31:0] digits;
    logic [7:0]  dp_mask, bad_mask;
    logic        frame_valid, frame_chg, dark, ghost_err;

    display_scan_decoder #(.N_DIGITS(ND), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .an_i(an), .dec_cat_i(dec_cat), .clr_err_i(clr_err),
        .digits_o(digits), .dp_mask_o(dp_mask), .bad_mask_o(bad_mask),
        .frame_valid_o(frame_valid), .frame_chg_o(frame_chg), .dark_o(dark), .ghost_err_o(ghost_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dig;
        logic [7:0]  dp;
        logic [7:0]  bad;
        logic        chg;
    } frame_t;

    frame_t      exp_q[$];
    int          total = 0;
    int          bad = 0;

    logic [6:0]  seg_tab[12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h00};
    logic [3:0]  nib_tab[12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};

    logic [3:0]  m_stg[ND];
    logic        m_dp[ND];
    logic        m_bad[ND];
    logic [ND-1:0] m_seen;
    logic [31:0] m_prev_dig;
    logic [7:0]  m_prev_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic dp);
        logic [7:0] r = {dp, 7'h00};
        for (int k = 0; k < 12; k++)
            if (nib_tab[k] == nib) r = {dp, seg_tab[k]};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_stg[i] = 4'hF; m_dp[i] = 1'b0; m_bad[i] = 1'b0;
        end
        m_seen     = '0;
        m_prev_dig = 32'hFFFF_FFFF;
        m_prev_dp  = 8'h00;
    endtask

    // Lookup-table decode, then frame bookkeeping at the granularity of whole dwells
    task automatic model_capture(input int d, input logic [7:0] seg8);
        frame_t f;
        logic [3:0] nib = 4'hE;
        logic       b   = 1'b1;
        for (int k = 0; k < 12; k++)
            if (seg_tab[k] == seg8[6:0]) begin nib = nib_tab[k]; b = 1'b0; end
        m_stg[d] = nib; m_bad[d] = b; m_dp[d] = seg8[7];
        m_seen[d] = 1'b1;
        if (&m_seen) begin
            for (int i = 0; i < ND; i++) begin
                f.dig[4*i +: 4] = m_stg[i];
                f.dp[i]  = m_dp[i];
                f.bad[i] = m_bad[i];
            end
            f.chg = ({f.dig, f.dp} != {m_prev_dig, m_prev_dp});
            m_prev_dig = f.dig;
            m_prev_dp  = f.dp;
            exp_q.push_back(f);
            m_seen = '0;
        end
    endtask

    task automatic dwell(input int d, input logic [7:0] seg8, input int len);
        if (len >= SETTLE) model_capture(d, seg8);
        an = ~(8'h01 << d);
        dec_cat = ~seg8;
        repeat (len) tick();
    endtask

    task automatic gap(input int len);
        if (len >= TIMEOUT) m_seen = '0;
        an = 8'hFF;
        dec_cat = 8'hFF;
        repeat (len) tick();
    endtask

    task automatic scan_frame(input logic [31:0] val, input logic [7:0] dps);
        for (int i = 0; i < ND; i++) dwell(i, seg_of(val[4*i +: 4], dps[i]), 10);
    endtask

    always @(negedge clk) begin
        frame_t e;
        if (rst_n && frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame_digits", digits, e.dig);
                check("frame_dp_mask", {24'h0, dp_mask}, {24'h0, e.dp});
                check("frame_bad_mask", {24'h0, bad_mask}, {24'h0, e.bad});
                check("frame_chg", {31'h0, frame_chg}, {31'h0, e.chg});
            end
        end else if (rst_n && frame_chg) begin
            check("frame_chg_without_valid", {31'h0, frame_chg}, 32'd0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last_seg, seg8;
        int         last_d, d, len, r;
        bit         last_dwell;

        rst_n = 1'b0; an = 8'hFF; dec_cat = 8'hFF; clr_err = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_digits", digits, 32'hFFFF_FFFF);
        check("reset_dp_mask", {24'h0, dp_mask}, 32'h0);
        check("reset_bad_mask", {24'h0, bad_mask}, 32'h0);
        check("reset_frame_valid", {31'h0, frame_valid}, 32'h0);
        check("reset_frame_chg", {31'h0, frame_chg}, 32'h0);
        check("reset_dark", {31'h0, dark}, 32'h0);
        check("reset_ghost_err", {31'h0, ghost_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        scan_frame(32'h0003_0102, 8'h00);
        gap(3);
        scan_frame(32'h0003_0102, 8'h00);
        gap(3);
        scan_frame(32'h0003_0502, 8'h00);
        gap(3);
        check("first_frames_drained", exp_q.size(), 32'd0);

        dwell(4, seg_of(4'h7, 1'b0), SETTLE - 1);
        for (int i = 0; i < ND; i++)
            if (i != 4) dwell(i, seg_of(4'h7, 1'b0), 10);
        gap(3);
        check("short_dwell_no_commit", {31'h0, frame_valid}, 32'h0);
        dwell(4, seg_of(4'h7, 1'b0), 10);
        gap(3);

        dwell(0, 8'h12, 10);
        dwell(1, 8'h86, 10);
        for (int i = 2; i < ND; i++) dwell(i, seg_of(4'h8, 1'b0), 10);
        gap(3);
        check("bad_nibble_E", {28'h0, digits[3:0]}, 32'hE);
        check("bad_mask_bit0", {31'h0, bad_mask[0]}, 32'h1);
        check("dp_digit1_nibble", {28'h0, digits[7:4]}, 32'h1);
        check("dp_mask_bit1", {31'h0, dp_mask[1]}, 32'h1);

        an = 8'b1111_1100; tick();
        gap(2);
        check("ghost_set", {31'h0, ghost_err}, 32'h1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("ghost_cleared", {31'h0, ghost_err}, 32'h0);
        an = 8'b1111_1100; tick();
        an = 8'hFF; clr_err = 1'b1; tick(); clr_err = 1'b0;
        tick();
        check("ghost_set_wins", {31'h0, ghost_err}, 32'h1);
        dwell(0, seg_of(4'h3, 1'b0), 2);
        an = 8'b1111_1100; tick();
        dwell(0, seg_of(4'h3, 1'b0), 2);
        for (int i = 1; i < ND; i++) dwell(i, seg_of(4'h3, 1'b0), 10);
        gap(3);
        check("ghost_sample_not_captured", exp_q.size(), 32'd0);
        dwell(0, seg_of(4'h3, 1'b0), 10);
        gap(3);

        for (int i = 0; i < 6; i++) dwell(i, seg_of(4'h9, 1'b1), 10);
        an = 8'hFF; dec_cat = 8'hFF;
        repeat (TIMEOUT) tick();
        check("dark_before_timeout", {31'h0, dark}, 32'h0);
        tick();
        check("dark_at_timeout", {31'h0, dark}, 32'h1);
        gap(3);
        m_seen = '0;
        dwell(0, seg_of(4'h9, 1'b1), 1);
        check("dark_clears_on_anode", {31'h0, dark}, 32'h0);
        dwell(6, seg_of(4'h9, 1'b1), 10);
        dwell(7, seg_of(4'h9, 1'b1), 10);
        gap(3);
        check("dark_drops_partial", exp_q.size(), 32'd0);
        scan_frame(32'h9999_9999, 8'hFF);
        gap(3);

        for (int i = 0; i < 3; i++) dwell(i, seg_of(4'h2, 1'b0), 10);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_digits", digits, 32'hFFFF_FFFF);
        check("midframe_reset_dp", {24'h0, dp_mask}, 32'h0);
        model_reset();
        an = 8'hFF; dec_cat = 8'hFF;
        tick();
        rst_n = 1'b1;
        tick();

        last_dwell = 1'b0; last_d = -1; last_seg = 8'h00;
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 19);
            if (r >= 12 && r <= 16) begin
                gap($urandom_range(1, 2)); last_dwell = 1'b0;
            end else if (r == 17) begin
                an = 8'hFF & ~(8'h01 << $urandom_range(0, 7)) & ~(8'h01 << $urandom_range(0, 7));
                if ($countones(~an) < 2) an[$urandom_range(0, 7)] = 1'b0;
                if ($countones(~an) < 2) an = 8'b0011_1111;
                tick(); last_dwell = 1'b0;
            end else if (r == 18) begin
                gap(TIMEOUT + 3); last_dwell = 1'b0;
            end
            d = $urandom_range(0, ND - 1);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                seg8 = {1'b0, 7'($urandom)};
                for (int k = 0; k < 12; k++)
                    if (seg_tab[k] == seg8[6:0]) seg8[6:0] = 7'h12;
            end else begin
                seg8 = {1'b0, seg_tab[$urandom_range(0, 11)]};
            end
            seg8[7] = ($urandom_range(0, 3) == 0);
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, SETTLE - 1) : $urandom_range(SETTLE, 9);
            if (last_dwell && d == last_d && seg8 == last_seg) gap(1);
            dwell(d, seg8, len);
            last_dwell = 1'b1; last_d = d; last_seg = seg8;
        end
        gap(4);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
